mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer that shares the single-ported memory behind the core. The instruction fetch unit (IFU) and the load/store unit (LSU) each issue one request at a time. The arbiter grants one of them, drives the memory request, waits for the response and routes it back to the owner. It sits between the fetch/`Data_mem` side of the CPU datapath and the external memory model, with at most one transaction outstanding.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/rr_arb2.sv | 24 ++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the IFU/LSU memory port arbiter.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_MASK_W = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and status signals of the arbiter, bundled as one interface.
// master: the arbiter's view; slave: the surrounding core/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::MEM_ADDR_W,
  parameter int DATA_W = mem_arb_pkg::MEM_DATA_W
);

  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_W-1:0]     ifu_addr;
  logic                  ifu_rvalid;
  logic [DATA_W-1:0]     ifu_rdata;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_W-1:0]     lsu_addr;
  logic                  lsu_wen;
  logic [DATA_W-1:0]     lsu_wdata;
  logic [DATA_W/8-1:0]   lsu_wmask;
  logic                  lsu_rvalid;
  logic [DATA_W-1:0]     lsu_rdata;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_wen;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic                  mem_resp_valid;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  err_spurious;

  modport master (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rvalid, ifu_rdata,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_rvalid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output err_spurious
  );

  modport slave (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rvalid, ifu_rdata,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_rvalid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  err_spurious
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on conflict the requester not served last wins.
// gnt_o is one-hot, bit 0 = IFU, bit 1 = LSU.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       req_ifu_i,
  input  logic       req_lsu_i,
  input  owner_e     last_owner_i,
  output logic [1:0] gnt_o
);

  // Grant decode from the two requests and the previous owner
  always_comb begin
    gnt_o = 2'b00;
    if (req_ifu_i && req_lsu_i) begin
      gnt_o = (last_owner_i == OWN_IFU) ? 2'b10 : 2'b01;
    end else if (req_ifu_i) begin
      gnt_o = 2'b01;
    end else if (req_lsu_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction outstanding.
//
//   state | meaning
//   IDLE  | no transaction; grant a requester and latch its payload
//   REQ   | mem_req_valid high with payload held until mem_req_ready
//   WAIT  | accepted by memory; route the response to the owner
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  arb_state_e            state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                last_owner_q, last_owner_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [MEM_DATA_W-1:0] wdata_q, wdata_d;
  logic [MEM_MASK_W-1:0] wmask_q, wmask_d;
  logic                  err_q, err_d;

  logic       req_ifu, req_lsu;
  logic [1:0] gnt;
  logic       ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid, mem_req_valid;

  // Requests are masked while reset is held so no ready leaks out during reset.
  assign req_ifu = bus.ifu_req_valid && rst;
  assign req_lsu = bus.lsu_req_valid && rst;

  rr_arb2 u_rr_arb2 (
    .req_ifu_i    (req_ifu),
    .req_lsu_i    (req_lsu),
    .last_owner_i (last_owner_q),
    .gnt_o        (gnt)
  );

  // State, ownership, payload and sticky error registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IFU;
      last_owner_q <= OWN_IFU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      err_q        <= err_d;
    end
  end

  // Next-state, grant/latch and response routing
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    err_d         = err_q;
    ifu_ready     = 1'b0;
    lsu_ready     = 1'b0;
    ifu_rvalid    = 1'b0;
    lsu_rvalid    = 1'b0;
    mem_req_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.mem_resp_valid) begin
          err_d = 1'b1;
        end
        if (gnt[0]) begin
          ifu_ready    = 1'b1;
          owner_d      = OWN_IFU;
          last_owner_d = OWN_IFU;
          addr_d       = bus.ifu_addr;
          wen_d        = 1'b0;
          wdata_d      = '0;
          wmask_d      = '1;
          state_d      = REQ;
        end else if (gnt[1]) begin
          lsu_ready    = 1'b1;
          owner_d      = OWN_LSU;
          last_owner_d = OWN_LSU;
          addr_d       = bus.lsu_addr;
          wen_d        = bus.lsu_wen;
          wdata_d      = bus.lsu_wdata;
          wmask_d      = bus.lsu_wmask;
          state_d      = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        // A response before the memory has even accepted the request is bogus.
        if (bus.mem_resp_valid) begin
          err_d = 1'b1;
        end
        if (bus.mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_resp_valid) begin
          if (owner_q == OWN_IFU) begin
            ifu_rvalid = 1'b1;
          end else begin
            lsu_rvalid = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ifu_req_ready = ifu_ready;
  assign bus.lsu_req_ready = lsu_ready;
  assign bus.ifu_rvalid    = ifu_rvalid;
  assign bus.lsu_rvalid    = lsu_rvalid;
  assign bus.ifu_rdata     = ifu_rvalid ? bus.mem_rdata : '0;
  // Write acks carry no data back to the LSU.
  assign bus.lsu_rdata     = (lsu_rvalid && !wen_q) ? bus.mem_rdata : '0;
  assign bus.mem_req_valid = mem_req_valid;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;
  assign bus.err_spurious  = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: who was served most recently, and the expected sticky error.
  bit last_lsu;
  bit exp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_addr       = '0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_addr       = '0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_wdata      = '0;
    bus.lsu_wmask      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ifu_ready"}, bus.ifu_req_ready, 0);
    chk({tag, "_lsu_ready"}, bus.lsu_req_ready, 0);
    chk({tag, "_ifu_rvalid"}, bus.ifu_rvalid, 0);
    chk({tag, "_lsu_rvalid"}, bus.lsu_rvalid, 0);
    chk({tag, "_ifu_rdata"}, bus.ifu_rdata, 0);
    chk({tag, "_lsu_rdata"}, bus.lsu_rdata, 0);
    chk({tag, "_mreq"}, bus.mem_req_valid, 0);
    chk({tag, "_maddr"}, bus.mem_addr, 0);
    chk({tag, "_mwen"}, bus.mem_wen, 0);
    chk({tag, "_mwdata"}, bus.mem_wdata, 0);
    chk({tag, "_mwmask"}, bus.mem_wmask, 0);
    chk({tag, "_err"}, bus.err_spurious, 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    clear_inputs();
    #1;
    chk_all_zero(tag);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    last_lsu = 1'b0;
    exp_err  = 1'b0;
  endtask

  // One complete transaction: grant, rdy_dly stall cycles in REQ, rsp_dly idle cycles in WAIT.
  task automatic do_txn(input bit iv, input logic [31:0] ia,
                        input bit lv, input logic [31:0] la, input bit lw,
                        input logic [31:0] lwd, input logic [3:0] lm,
                        input int rdy_dly, input int rsp_dly, input logic [31:0] rd);
    bit          g_lsu;
    logic [31:0] e_addr, e_wdata;
    logic        e_wen;
    logic [3:0]  e_mask;
    bus.ifu_req_valid  = iv;
    bus.ifu_addr       = ia;
    bus.lsu_req_valid  = lv;
    bus.lsu_addr       = la;
    bus.lsu_wen        = lw;
    bus.lsu_wdata      = lwd;
    bus.lsu_wmask      = lm;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    g_lsu    = (iv && lv) ? !last_lsu : lv;
    last_lsu = g_lsu;
    if (g_lsu) begin
      e_addr = la; e_wen = lw; e_wdata = lwd; e_mask = lm;
    end else begin
      e_addr = ia; e_wen = 1'b0; e_wdata = 32'h0; e_mask = 4'hF;
    end
    @(negedge clk);
    chk("grant_ifu_ready", bus.ifu_req_ready, !g_lsu);
    chk("grant_lsu_ready", bus.lsu_req_ready, g_lsu);
    chk("grant_mreq_low", bus.mem_req_valid, 0);
    @(posedge clk);
    #1;
    // Owner releases and scrambles its payload; the latched copy must not follow.
    if (g_lsu) begin
      bus.lsu_req_valid = 1'b0;
      bus.lsu_addr      = ~la;
      bus.lsu_wdata     = ~lwd;
      bus.lsu_wmask     = ~lm;
      bus.lsu_wen       = ~lw;
    end else begin
      bus.ifu_req_valid = 1'b0;
      bus.ifu_addr      = ~ia;
    end
    for (int k = 0; k <= rdy_dly; k++) begin
      bus.mem_req_ready = (k == rdy_dly);
      @(negedge clk);
      chk("req_mreq", bus.mem_req_valid, 1);
      chk("req_addr", bus.mem_addr, e_addr);
      chk("req_wen", bus.mem_wen, e_wen);
      chk("req_wdata", bus.mem_wdata, e_wdata);
      chk("req_wmask", bus.mem_wmask, e_mask);
      chk("req_no_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
      @(posedge clk);
      #1;
    end
    bus.mem_req_ready = 1'b0;
    for (int j = 0; j < rsp_dly; j++) begin
      @(negedge clk);
      chk("wait_mreq_low", bus.mem_req_valid, 0);
      chk("wait_no_rvalid", {bus.ifu_rvalid, bus.lsu_rvalid}, 0);
      chk("wait_no_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
      @(posedge clk);
      #1;
    end
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = rd;
    @(negedge clk);
    chk("rsp_ifu_rvalid", bus.ifu_rvalid, !g_lsu);
    chk("rsp_lsu_rvalid", bus.lsu_rvalid, g_lsu);
    chk("rsp_ifu_rdata", bus.ifu_rdata, g_lsu ? 32'h0 : rd);
    chk("rsp_lsu_rdata", bus.lsu_rdata, (g_lsu && !e_wen) ? rd : 32'h0);
    chk("rsp_err", bus.err_spurious, exp_err);
    @(posedge clk);
    #1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  task automatic spurious_pulse(input string tag);
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h1234_5678;
    @(negedge clk);
    chk({tag, "_no_rvalid"}, {bus.ifu_rvalid, bus.lsu_rvalid}, 0);
    chk({tag, "_no_rdata"}, {bus.ifu_rdata, bus.lsu_rdata}, 0);
    @(posedge clk);
    #1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    exp_err = 1'b1;
    @(negedge clk);
    chk({tag, "_err_set"}, bus.err_spurious, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          pi, pl, lw;
    logic [31:0] ia, la, lwd;
    logic [3:0]  lm;

    do_reset("reset0");

    // IFU alone, memory ready at once, response one WAIT cycle later.
    do_txn(1, 32'h8000_0000, 0, 32'h0, 0, 32'h0, 4'h0, 0, 1, 32'h0000_0297);

    // Conflicts after reset: LSU, then IFU, then LSU.
    do_reset("reset1");
    for (int c = 0; c < 3; c++) begin
      do_txn(1, 32'h8000_0100, 1, 32'h8000_0200, 0, 32'h0, 4'hF, 0, 0, $urandom);
      chk("conflict_order", last_lsu, (c != 1));
    end

    // LSU write with a long memory stall; ack carries no data.
    do_txn(0, 32'h0, 1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'b0011, 4, 1, 32'hCAFE_F00D);

    // Response with nothing outstanding; error stays set afterwards.
    spurious_pulse("spur_idle");
    do_txn(1, 32'h8000_0040, 0, 32'h0, 0, 32'h0, 4'h0, 1, 2, 32'h1111_2222);
    do_txn(0, 32'h0, 1, 32'h8000_0044, 0, 32'h0, 4'hF, 0, 0, 32'h3333_4444);

    // Reset while a read is waiting for its response.
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_2000;
    bus.mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.ifu_req_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    chk("midwait_mreq_low", bus.mem_req_valid, 0);
    chk("midwait_addr", bus.mem_addr, 32'h8000_2000);
    @(posedge clk);
    #1;
    do_reset("reset_wait");
    spurious_pulse("spur_stale");
    do_txn(1, 32'h8000_3000, 0, 32'h0, 0, 32'h0, 4'h0, 0, 0, 32'hABCD_0123);

    // Randomized traffic; a requester that loses a conflict keeps its request.
    do_reset("reset2");
    pi = 0; pl = 0; ia = 0; la = 0; lwd = 0; lw = 0; lm = 0;
    for (int t = 0; t < 40; t++) begin
      if (!pi) begin
        pi = ($urandom_range(0, 1) == 1);
        ia = $urandom;
      end
      if (!pl) begin
        pl  = ($urandom_range(0, 1) == 1);
        la  = $urandom;
        lw  = ($urandom_range(0, 1) == 1);
        lwd = $urandom;
        lm  = 4'($urandom_range(0, 15));
      end
      if (!pi && !pl) begin
        pi = 1;
        ia = $urandom;
      end
      do_txn(pi, ia, pl, la, lw, lwd, lm,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if (last_lsu) pl = 0;
      else pi = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
